// File: rtl/addn_accum_if.sv
// Operand-in / result-out handshake bundle for the sequential N-operand accumulator.
interface addn_accum_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4,
  parameter int SUM_W   = 5
);
  localparam int CNT_W = $clog2(NUM_OPS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum;
  logic             ov;
  logic [CNT_W-1:0] op_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, ov, op_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, ov, op_cnt
  );
endinterface

// File: rtl/addn_accum.sv
// Sequential NUM_OPS-operand unsigned adder: one operand per accepted beat, result held
// with backpressure until the consumer takes it. Truncated sum plus overflow flag.
module addn_accum #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4,
  parameter int SUM_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  addn_accum_if.slave bus
);
  // Wide enough that NUM_OPS maximal operands never wrap.
  localparam int ACC_W = WIDTH + $clog2(NUM_OPS);
  localparam int CNT_W = $clog2(NUM_OPS + 1);

  typedef enum logic {S_ACC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ov_q, ov_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  assign acc_sum = acc_q + ACC_W'(bus.in_data);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    ov_d        = ov_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_ACC: begin
        if (bus.in_valid && in_ready_q) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          // Result is captured from the final total, not from acc_q, so it is ready next cycle.
          if (cnt_q == CNT_W'(NUM_OPS - 1)) begin
            sum_d       = acc_sum[SUM_W-1:0];
            ov_d        = |acc_sum[ACC_W-1:SUM_W];
            state_d     = S_DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = S_ACC;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      ov_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      ov_q        <= ov_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ov        = ov_q;
  assign bus.op_cnt    = cnt_q;
endmodule

// File: tb/tb_addn_accum.sv
// Scoreboard bench: drivers push expected totals, monitors pop on each result handshake.
module tb_addn_accum;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  addn_accum_if #(.WIDTH(4), .NUM_OPS(4), .SUM_W(5)) ia ();
  addn_accum_if #(.WIDTH(8), .NUM_OPS(5), .SUM_W(9)) ib ();

  addn_accum #(.WIDTH(4), .NUM_OPS(4), .SUM_W(5)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  addn_accum #(.WIDTH(8), .NUM_OPS(5), .SUM_W(9)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

  int checks = 0, errors = 0;
  int qa[$], qb[$];
  int acc_a = 0, cnt_a = 0, acc_b = 0, cnt_b = 0;
  bit done_a = 0, done_b = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  // Reference: true sum of the operands; output is that sum mod 2**SUM_W, ov when it doesn't fit.
  task automatic send_a(input int op);
    int n = 0;
    ia.in_valid = 1'b1;
    ia.in_data  = 4'(op);
    @(negedge clk);
    while (!ia.in_ready && n < 64) begin n++; @(negedge clk); end
    if (!ia.in_ready) chk("a_accept_timeout", 0, 1);
    else begin
      acc_a += op; cnt_a++;
      if (cnt_a == 4) begin qa.push_back(acc_a); acc_a = 0; cnt_a = 0; end
    end
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
  endtask

  task automatic send_b(input int op);
    int n = 0;
    ib.in_valid = 1'b1;
    ib.in_data  = 8'(op);
    @(negedge clk);
    while (!ib.in_ready && n < 64) begin n++; @(negedge clk); end
    if (!ib.in_ready) chk("b_accept_timeout", 0, 1);
    else begin
      acc_b += op; cnt_b++;
      if (cnt_b == 5) begin qb.push_back(acc_b); acc_b = 0; cnt_b = 0; end
    end
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_a && ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        int t;
        t = qa.pop_front();
        chk("a_sum", ia.sum, t % 32);
        chk("a_ov", ia.ov, (t >= 32) ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        int t;
        t = qb.pop_front();
        chk("b_sum", ib.sum, t % 512);
        chk("b_ov", ib.ov, (t >= 512) ? 1 : 0);
      end
    end
  end

  initial begin : main_a
    bit stop;
    ia.in_valid = 1'b0; ia.in_data = '0; ia.out_ready = 1'b1;
    rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    chk("a_rst_in_ready", ia.in_ready, 1);
    chk("a_rst_out_valid", ia.out_valid, 0);
    chk("a_rst_sum", ia.sum, 0);
    chk("a_rst_ov", ia.ov, 0);
    chk("a_rst_op_cnt", ia.op_cnt, 0);
    @(posedge clk); #1;

    // T1: back-to-back, result visible the cycle after the 4th accept
    send_a(1); send_a(2); send_a(3); send_a(4);
    chk("t1_latency_valid", ia.out_valid, 1);
    chk("t1_op_cnt_done", ia.op_cnt, 4);
    chk("t1_in_ready_done", ia.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t1_op_cnt_handoff", ia.op_cnt, 0);
    chk("t1_valid_dropped", ia.out_valid, 0);

    // T2: truncation boundaries
    send_a(15); send_a(15); send_a(1); send_a(0);
    send_a(15); send_a(15); send_a(2); send_a(0);
    for (int i = 0; i < 4; i++) send_a(15);

    // T3: alternate-cycle valid, op_cnt moves only on accepts
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send_a(5 + i);
      if (i < 3) begin
        chk("t3_op_cnt", ia.op_cnt, i + 1);
        @(posedge clk); #1;
        chk("t3_op_cnt_idle", ia.op_cnt, i + 1);
      end
    end
    repeat (2) @(posedge clk); #1;

    // T4: backpressure with an operand waiting
    ia.out_ready = 1'b0;
    send_a(2); send_a(3); send_a(4); send_a(5);
    ia.in_valid = 1'b1; ia.in_data = 4'd9;
    repeat (3) begin
      @(negedge clk);
      chk("t4_in_ready", ia.in_ready, 0);
      chk("t4_out_valid", ia.out_valid, 1);
      chk("t4_sum_stable", ia.sum, 14);
      chk("t4_op_cnt", ia.op_cnt, 4);
    end
    @(posedge clk); #1;
    ia.out_ready = 1'b1;
    send_a(9); send_a(1); send_a(1); send_a(1);
    repeat (2) @(posedge clk); #1;

    // T5: reset mid-accumulation discards the partial sum
    send_a(7); send_a(7);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    acc_a = 0; cnt_a = 0;
    chk("t5_op_cnt", ia.op_cnt, 0);
    chk("t5_out_valid", ia.out_valid, 0);
    chk("t5_in_ready", ia.in_ready, 1);
    send_a(1); send_a(1); send_a(1); send_a(1);
    repeat (2) @(posedge clk); #1;

    // T6: random sweep with random gaps and backpressure
    stop = 0;
    fork
      begin
        for (int i = 0; i < 4800; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_a($urandom_range(0, 15));
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          ia.out_ready = ($urandom_range(0, 3) != 0);
        end
        ia.out_ready = 1'b1;
      end
    join
    done_a = 1;
  end

  initial begin : main_b
    bit stop;
    ib.in_valid = 1'b0; ib.in_data = '0; ib.out_ready = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("b_rst_in_ready", ib.in_ready, 1);
    chk("b_rst_out_valid", ib.out_valid, 0);
    chk("b_rst_op_cnt", ib.op_cnt, 0);
    @(posedge clk); #1;
    // Corner: all-max operands, then all-zero
    for (int i = 0; i < 5; i++) send_b(255);
    for (int i = 0; i < 5; i++) send_b(0);
    stop = 0;
    fork
      begin
        for (int i = 0; i < 5000; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_b(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
        end
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          ib.out_ready = ($urandom_range(0, 3) != 0);
        end
        ib.out_ready = 1'b1;
      end
    join
    done_b = 1;
  end

  initial begin : finish_ctl
    wait (done_a && done_b);
    repeat (8) @(posedge clk);
    chk("a_drain", qa.size(), 0);
    chk("b_drain", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end
endmodule
